// File: rtl/nn_train_sequencer.sv
// nn_train_sequencer: phase controller for the single-layer training datapath.
// Walks LOAD -> DRAIN -> (FWD -> SIG -> BWD) x epochs -> DONE. Along the way it
// generates every row/column index and BROM address the datapath consumes.
module nn_train_sequencer #(
  parameter int ROWS   = 784,
  parameter int COLS   = 40,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 7,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        epochs,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase,
  output logic              load_en,
  output logic              fwd_en,
  output logic              sig_en,
  output logic              bwd_en,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              wrom_en,
  output logic              wr_valid,
  output logic [ROW_W-1:0]  wr_row,
  output logic [COL_W-1:0]  wr_col,
  output logic              first_acc,
  output logic [7:0]        epoch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_FWD   = 3'd3,
    S_SIG   = 3'd4,
    S_BWD   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic [COL_W-1:0] col_nxt;
  logic [7:0]       epoch_nxt;
  logic [7:0]       epoch_target;
  logic             latch_target;
  logic             last_row, last_col;

  assign last_row = (row == ROW_W'(ROWS - 1));
  assign last_col = (col == COL_W'(COLS - 1));

  // Next state and next indices: each phase walks its own loop order, and abort overrides everything.
  always_comb begin
    state_nxt    = state;
    row_nxt      = row;
    col_nxt      = col;
    epoch_nxt    = epoch_cnt;
    latch_target = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_LOAD;
          row_nxt      = '0;
          col_nxt      = '0;
          epoch_nxt    = '0;
          latch_target = 1'b1;
        end
      end
      S_LOAD, S_FWD: begin
        if (last_row) begin
          row_nxt = '0;
          if (last_col) begin
            col_nxt   = '0;
            state_nxt = (state == S_LOAD) ? S_DRAIN : S_SIG;
          end else begin
            col_nxt = col + 1'b1;
          end
        end else begin
          row_nxt = row + 1'b1;
        end
      end
      S_DRAIN: begin
        state_nxt = S_FWD;
        row_nxt   = '0;
        col_nxt   = '0;
      end
      S_SIG: begin
        row_nxt = '0;
        if (last_col) begin
          col_nxt   = '0;
          state_nxt = S_BWD;
        end else begin
          col_nxt = col + 1'b1;
        end
      end
      S_BWD: begin
        if (last_col) begin
          col_nxt = '0;
          if (last_row) begin
            row_nxt   = '0;
            epoch_nxt = epoch_cnt + 8'd1;
            state_nxt = ((epoch_cnt + 8'd1) == epoch_target) ? S_DONE : S_FWD;
          end else begin
            row_nxt = row + 1'b1;
          end
        end else begin
          col_nxt = col + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        row_nxt   = '0;
        col_nxt   = '0;
      end
    endcase
    if (abort) begin
      state_nxt    = S_IDLE;
      row_nxt      = '0;
      col_nxt      = '0;
      epoch_nxt    = epoch_cnt;
      latch_target = 1'b0;
    end
  end

  // State, index and address registers; the BROM write-back tags are cleared whenever IDLE is entered so IDLE shows all-zero outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      epoch_cnt    <= '0;
      epoch_target <= 8'd1;
      rom_addr     <= '0;
      wr_valid     <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      epoch_cnt <= epoch_nxt;
      rom_addr  <= ADDR_W'(col_nxt) * ADDR_W'(ROWS) + ADDR_W'(row_nxt);
      if (latch_target) begin
        epoch_target <= (epochs == 8'd0) ? 8'd1 : epochs;
      end
      if (state_nxt == S_IDLE) begin
        wr_valid <= 1'b0;
        wr_row   <= '0;
        wr_col   <= '0;
      end else begin
        wr_valid <= (state == S_LOAD);
        wr_row   <= row;
        wr_col   <= col;
      end
    end
  end

  // Phase strobes and enables decoded from the registered state and indices only.
  always_comb begin
    phase     = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    load_en   = (state == S_LOAD);
    fwd_en    = (state == S_FWD);
    sig_en    = (state == S_SIG);
    bwd_en    = (state == S_BWD);
    rom_en    = (state == S_LOAD);
    wrom_en   = (state == S_LOAD) && (col == '0);
    first_acc = (state == S_FWD) && (row == '0);
  end

endmodule

// File: tb/tb_nn_train_sequencer.sv
// tb_nn_train_sequencer: directed bench for the training phase sequencer using ROWS=4, COLS=3.
// A cycle-index model gives the expected phase, indices and epoch count for every cycle of a run.
module tb_nn_train_sequencer;

  localparam int ROWS   = 4;
  localparam int COLS   = 3;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 2;
  localparam int ADDR_W = 4;
  localparam int L      = ROWS * COLS;
  localparam int P      = 2 * L + COLS;

  typedef struct packed {
    int ph;
    int r;
    int cl;
    int ep;
  } mdl_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [7:0]        epochs;
  logic              busy, done, load_en, fwd_en, sig_en, bwd_en;
  logic [2:0]        phase;
  logic [ROW_W-1:0]  row, wr_row;
  logic [COL_W-1:0]  col, wr_col;
  logic              rom_en, wrom_en, wr_valid, first_acc;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        epoch_cnt;

  int total = 0;
  int bad   = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  nn_train_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .epochs(epochs),
    .busy(busy), .done(done), .phase(phase),
    .load_en(load_en), .fwd_en(fwd_en), .sig_en(sig_en), .bwd_en(bwd_en),
    .row(row), .col(col), .rom_en(rom_en), .rom_addr(rom_addr), .wrom_en(wrom_en),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_col(wr_col),
    .first_acc(first_acc), .epoch_cnt(epoch_cnt)
  );

  // Expected state for cycle c of a run (cycle 0 = first LOAD cycle); negative c means idle before the run.
  function automatic mdl_t model(input int c, input int e_count);
    mdl_t m;
    int t, e, u, v;
    m = '{ph: 0, r: 0, cl: 0, ep: 0};
    if (c < 0) return m;
    if (c < L) begin
      m.ph = 1; m.r = c % ROWS; m.cl = c / ROWS;
      return m;
    end
    if (c == L) begin
      m.ph = 2;
      return m;
    end
    t = c - L - 1;
    e = t / P;
    u = t % P;
    if (t >= e_count * P) begin
      m.ep = e_count;
      m.ph = (t == e_count * P) ? 6 : 0;
      return m;
    end
    m.ep = e;
    if (u < L) begin
      m.ph = 3; m.r = u % ROWS; m.cl = u / ROWS;
    end else if (u < L + COLS) begin
      m.ph = 4; m.r = 0; m.cl = u - L;
    end else begin
      v = u - L - COLS;
      m.ph = 5; m.r = v / COLS; m.cl = v % COLS;
    end
    return m;
  endfunction

  task automatic applyStimulus(input logic s, input logic a, input logic [7:0] e);
    start  = s;
    abort  = a;
    epochs = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input int c, input int e_count);
    mdl_t m, p;
    m = model(c, e_count);
    p = model(c - 1, e_count);
    checkOutput($sformatf("c%0d_phase", c),     phase,     m.ph);
    checkOutput($sformatf("c%0d_busy", c),      busy,      m.ph != 0);
    checkOutput($sformatf("c%0d_load_en", c),   load_en,   m.ph == 1);
    checkOutput($sformatf("c%0d_fwd_en", c),    fwd_en,    m.ph == 3);
    checkOutput($sformatf("c%0d_sig_en", c),    sig_en,    m.ph == 4);
    checkOutput($sformatf("c%0d_bwd_en", c),    bwd_en,    m.ph == 5);
    checkOutput($sformatf("c%0d_done", c),      done,      m.ph == 6);
    checkOutput($sformatf("c%0d_row", c),       row,       m.r);
    checkOutput($sformatf("c%0d_col", c),       col,       m.cl);
    checkOutput($sformatf("c%0d_rom_en", c),    rom_en,    m.ph == 1);
    checkOutput($sformatf("c%0d_rom_addr", c),  rom_addr,  m.cl * ROWS + m.r);
    checkOutput($sformatf("c%0d_wrom_en", c),   wrom_en,   (m.ph == 1) && (m.cl == 0));
    checkOutput($sformatf("c%0d_first_acc", c), first_acc, (m.ph == 3) && (m.r == 0));
    checkOutput($sformatf("c%0d_epoch_cnt", c), epoch_cnt, m.ep);
    checkOutput($sformatf("c%0d_wr_valid", c),  wr_valid,  p.ph == 1);
    checkOutput($sformatf("c%0d_wr_row", c),    wr_row,    p.r);
    checkOutput($sformatf("c%0d_wr_col", c),    wr_col,    p.cl);
  endtask

  initial begin
    // Power-on reset: everything zero, including epoch_cnt.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0);
    repeat (3) step();
    checkCycle(-1, 1);
    rst = 1'b1;
    step();
    checkCycle(-1, 1);

    // Two-epoch run with full per-cycle checks; done lands in cycle 67.
    applyStimulus(1'b1, 1'b0, 8'd2);
    step();
    applyStimulus(1'b0, 1'b0, 8'd2);
    for (int c = 0; c <= 69; c++) begin
      checkCycle(c, 2);
      step();
    end
    checkOutput("idle_holds_epoch_cnt", epoch_cnt, 32'd2);

    // Abort during SIG (cycle 26): IDLE in cycle 27, no done, epoch_cnt stays 0.
    applyStimulus(1'b1, 1'b0, 8'd2);
    step();
    applyStimulus(1'b0, 1'b0, 8'd2);
    for (int c = 0; c <= 26; c++) begin
      checkCycle(c, 2);
      if (c == 26) applyStimulus(1'b0, 1'b1, 8'd2);
      step();
    end
    applyStimulus(1'b0, 1'b0, 8'd2);
    checkOutput("abort_phase",     phase,     32'd0);
    checkOutput("abort_busy",      busy,      32'd0);
    checkOutput("abort_sig_en",    sig_en,    32'd0);
    checkOutput("abort_col",       col,       32'd0);
    checkOutput("abort_wr_valid",  wr_valid,  32'd0);
    checkOutput("abort_epoch_cnt", epoch_cnt, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("abort_no_done_%0d", i), done, 32'd0);
      step();
    end

    // A fresh start after the abort runs a complete single-epoch sequence.
    applyStimulus(1'b1, 1'b0, 8'd1);
    step();
    applyStimulus(1'b0, 1'b0, 8'd1);
    for (int c = 0; c <= 41; c++) begin
      checkCycle(c, 1);
      step();
    end

    // epochs=0 behaves as one epoch; start (with a different epochs value) while busy is ignored.
    applyStimulus(1'b1, 1'b0, 8'd0);
    step();
    applyStimulus(1'b0, 1'b0, 8'd0);
    for (int c = 0; c <= 42; c++) begin
      checkCycle(c, 1);
      if (c == 5 || c == 30) applyStimulus(1'b1, 1'b0, 8'd3);
      else                   applyStimulus(1'b0, 1'b0, 8'd0);
      step();
    end

    // Asynchronous reset in the second epoch's FWD phase clears outputs before the next edge.
    applyStimulus(1'b1, 1'b0, 8'd2);
    step();
    applyStimulus(1'b0, 1'b0, 8'd2);
    for (int c = 0; c <= 44; c++) begin
      checkCycle(c, 2);
      step();
    end
    checkOutput("pre_reset_fwd_en",    fwd_en,    32'd1);
    checkOutput("pre_reset_epoch_cnt", epoch_cnt, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkCycle(-1, 2);
    step();
    rst = 1'b1;
    step();
    checkCycle(-1, 2);
    checkOutput("post_reset_busy", busy, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
